// File: rtl/ixu_issue_ctrl.sv
// In-order issue controller for one VLIW IXU slot.
// Decoded ops are queued in a small FIFO. The FIFO head is held while either of
// its source registers is still owed a result by an op that has already issued,
// which is tracked by a 32-entry scoreboard. The register file writes before it
// reads, so a result that is being written back this cycle already counts as
// available. Writeback strobes come from a fixed-latency {valid,rd} shift
// register.
module ixu_issue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int EX_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic        in_is_nop,
    input  logic        in_is_imm,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [11:0] in_imm,
    input  logic        stall_in,
    input  logic        flush,
    output logic        iss_valid,
    output logic [3:0]  iss_op,
    output logic        iss_is_imm,
    output logic [4:0]  iss_rs1,
    output logic [4:0]  iss_rs2,
    output logic [4:0]  iss_rd,
    output logic [11:0] iss_imm,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        err_illegal,
    output logic [15:0] stall_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [3:0]  op;
        logic        is_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] imm;
    } op_t;

    op_t              fifo_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      busy_r;
    logic [EX_LAT-1:0] pipe_v_r;
    logic [4:0]       pipe_rd_r [EX_LAT];

    logic             full_s;
    logic             accept_s;
    logic             legal_s;
    logic             push_s;
    logic             illegal_s;
    logic             head_valid_s;
    op_t              head_s;
    logic [31:0]      busy_eff_s;
    logic [31:0]      busy_nxt_s;
    logic             hazard_s;
    logic             pop_s;
    logic             stall_evt_s;

    assign full_s       = (count_r == FULL_CNT);
    assign in_ready     = !full_s && !rst && !flush;
    assign accept_s     = in_valid && in_ready;
    assign legal_s      = (in_op <= 4'd9);
    assign push_s       = accept_s && !in_is_nop && legal_s;
    assign illegal_s    = accept_s && !in_is_nop && !legal_s;
    assign head_valid_s = (count_r != {CNT_W{1'b0}});
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign pop_s        = head_valid_s && !hazard_s && !stall_in && !flush;
    assign stall_evt_s  = head_valid_s && hazard_s && !stall_in && !flush;
    assign wb_valid     = pipe_v_r[EX_LAT-1];
    assign wb_rd        = pipe_rd_r[EX_LAT-1];

    // Busy view for this cycle: the register being written back is already readable.
    always_comb begin
        busy_eff_s = busy_r;
        if (wb_valid) begin
            busy_eff_s[wb_rd] = 1'b0;
        end else begin
            busy_eff_s = busy_r;
        end
    end

    // RAW check on the FIFO head; x0 and the unused rs2 of I-type ops never block.
    always_comb begin
        hazard_s = 1'b0;
        if (head_valid_s) begin
            hazard_s = ((head_s.rs1 != 5'd0) && busy_eff_s[head_s.rs1]) ||
                       (!head_s.is_imm && (head_s.rs2 != 5'd0) && busy_eff_s[head_s.rs2]);
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Next scoreboard value: writeback clears first, so a same-cycle issue to that register wins.
    always_comb begin
        busy_nxt_s = busy_eff_s;
        if (pop_s && (head_s.rd != 5'd0)) begin
            busy_nxt_s[head_s.rd] = 1'b1;
        end else begin
            busy_nxt_s = busy_eff_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // FIFO storage: payload only, validity is carried by the count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= '{op: in_op, is_imm: in_is_imm, rs1: in_rs1,
                                      rs2: in_rs2, rd: in_rd, imm: in_imm};
        end
    end

    // FIFO pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Register scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Issue register: fields hold between issues, valid is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid  <= 1'b0;
            iss_op     <= 4'd0;
            iss_is_imm <= 1'b0;
            iss_rs1    <= 5'd0;
            iss_rs2    <= 5'd0;
            iss_rd     <= 5'd0;
            iss_imm    <= 12'd0;
        end else begin
            iss_valid <= pop_s;
            if (pop_s) begin
                iss_op     <= head_s.op;
                iss_is_imm <= head_s.is_imm;
                iss_rs1    <= head_s.rs1;
                iss_rs2    <= head_s.rs2;
                iss_rd     <= head_s.rd;
                iss_imm    <= head_s.imm;
            end
        end
    end

    // Writeback delay line; reset drops every in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v_r <= {EX_LAT{1'b0}};
            for (int k = 0; k < EX_LAT; k++) begin
                pipe_rd_r[k] <= 5'd0;
            end
        end else begin
            pipe_v_r[0]  <= iss_valid;
            pipe_rd_r[0] <= iss_valid ? iss_rd : 5'd0;
            for (int k = 1; k < EX_LAT; k++) begin
                pipe_v_r[k]  <= pipe_v_r[k-1];
                pipe_rd_r[k] <= pipe_rd_r[k-1];
            end
        end
    end

    // Illegal-opcode pulse, one cycle after the offending op is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= illegal_s;
        end
    end

    // Saturating count of cycles lost to RAW hazards alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (stall_evt_s && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ixu_issue_ctrl.sv
// Bench for ixu_issue_ctrl: a queue-based reference model is compared against
// the DUT every cycle, directed scenarios pin the model with literal timings,
// and a randomized phase follows.
module tb_ixu_issue_ctrl;

    localparam int DEPTH  = 4;
    localparam int EX_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_is_nop, in_is_imm, stall_in, flush;
    logic [3:0]  in_op;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [11:0] in_imm;
    logic        in_ready, iss_valid, iss_is_imm, wb_valid, err_illegal;
    logic [3:0]  iss_op;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd, wb_rd;
    logic [11:0] iss_imm;
    logic [15:0] stall_cnt;

    ixu_issue_ctrl #(.DEPTH(DEPTH), .EX_LAT(EX_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_is_nop(in_is_nop), .in_is_imm(in_is_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .stall_in(stall_in), .flush(flush),
        .iss_valid(iss_valid), .iss_op(iss_op), .iss_is_imm(iss_is_imm),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_imm(iss_imm),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .err_illegal(err_illegal),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic        is_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] imm;
    } mop_t;

    // reference model state
    mop_t     m_fifo[$];
    bit       m_busy[32];
    int       m_wb_due[$];
    bit [4:0] m_wb_rd[$];
    mop_t     m_iss;
    bit       m_iss_valid;
    bit       m_err;
    int       m_stall;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int       obs_iss_cyc[$];
    bit [4:0] obs_iss_rd[$];
    int       obs_wb_cyc[$];
    bit [4:0] obs_wb_rd[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        bit   wb_now;
        bit [4:0] wb_r;
        bit   eff[32];
        bit   has_head, haz, pop, acc;
        mop_t h;
        if (rst) begin
            m_fifo.delete(); m_wb_due.delete(); m_wb_rd.delete();
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            m_iss = '0; m_iss_valid = 1'b0; m_err = 1'b0; m_stall = 0;
            return;
        end
        wb_now = (m_wb_due.size() > 0) && (m_wb_due[0] == cyc);
        wb_r   = 5'd0;
        if (wb_now) begin
            wb_r = m_wb_rd[0];
            void'(m_wb_due.pop_front());
            void'(m_wb_rd.pop_front());
        end
        for (int r = 0; r < 32; r++) eff[r] = m_busy[r] && !(wb_now && wb_r == r);
        has_head = (m_fifo.size() > 0);
        haz = 1'b0;
        h = '0;
        if (has_head) begin
            h = m_fifo[0];
            haz = (h.rs1 != 0 && eff[h.rs1]) || (!h.is_imm && h.rs2 != 0 && eff[h.rs2]);
        end
        pop = has_head && !haz && !stall_in && !flush;
        if (has_head && haz && !stall_in && !flush && m_stall < 65535) m_stall++;
        acc = in_valid && (m_fifo.size() < DEPTH) && !flush;
        m_err = acc && !in_is_nop && (in_op > 9);
        for (int r = 0; r < 32; r++) m_busy[r] = eff[r];
        if (pop && h.rd != 0) m_busy[h.rd] = 1'b1;
        m_iss_valid = pop;
        if (pop) begin
            m_iss = h;
            m_wb_due.push_back(cyc + 1 + EX_LAT);
            m_wb_rd.push_back(h.rd);
            void'(m_fifo.pop_front());
        end
        if (flush) m_fifo.delete();
        else if (acc && !in_is_nop && in_op <= 9)
            m_fifo.push_back('{op: in_op, is_imm: in_is_imm, rs1: in_rs1, rs2: in_rs2,
                               rd: in_rd, imm: in_imm});
    endtask

    // One clock: compare on the falling edge, advance the model, drive after the rising edge.
    task automatic cycle();
        bit exp_wb;
        bit exp_ready;
        @(negedge clk);
        exp_wb    = (m_wb_due.size() > 0) && (m_wb_due[0] == cyc);
        exp_ready = (m_fifo.size() < DEPTH) && !rst && !flush;
        chk("in_ready",    32'(in_ready),    32'(exp_ready));
        chk("iss_valid",   32'(iss_valid),   32'(m_iss_valid));
        chk("iss_op",      32'(iss_op),      32'(m_iss.op));
        chk("iss_is_imm",  32'(iss_is_imm),  32'(m_iss.is_imm));
        chk("iss_rs1",     32'(iss_rs1),     32'(m_iss.rs1));
        chk("iss_rs2",     32'(iss_rs2),     32'(m_iss.rs2));
        chk("iss_rd",      32'(iss_rd),      32'(m_iss.rd));
        chk("iss_imm",     32'(iss_imm),     32'(m_iss.imm));
        chk("wb_valid",    32'(wb_valid),    32'(exp_wb));
        if (exp_wb) chk("wb_rd", 32'(wb_rd), 32'(m_wb_rd[0]));
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
        chk("stall_cnt",   32'(stall_cnt),   32'(m_stall));
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (iss_valid) begin obs_iss_cyc.push_back(cyc); obs_iss_rd.push_back(iss_rd); end
        if (wb_valid)  begin obs_wb_cyc.push_back(cyc);  obs_wb_rd.push_back(wb_rd);   end
    endtask

    task automatic set_op(input bit nop, input bit imm_t, input bit [3:0] op,
                          input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                          input bit [11:0] iv);
        in_valid = 1'b1; in_is_nop = nop; in_is_imm = imm_t; in_op = op;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = iv;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        cycle();
        rst = 1'b0;
        obs_iss_cyc.delete(); obs_iss_rd.delete(); obs_wb_cyc.delete(); obs_wb_rd.delete();
    endtask

    function automatic int iss_at(input bit [4:0] rd);
        foreach (obs_iss_cyc[i]) if (obs_iss_rd[i] == rd) return obs_iss_cyc[i];
        return -1;
    endfunction

    function automatic int wb_at(input bit [4:0] rd);
        foreach (obs_wb_cyc[i]) if (obs_wb_rd[i] == rd) return obs_wb_cyc[i];
        return -1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        rst = 1'b1; in_valid = 1'b0; in_is_nop = 1'b0; in_is_imm = 1'b0; in_op = 4'd0;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_imm = 12'd0;
        stall_in = 1'b0; flush = 1'b0;
        m_iss = '0;
        @(posedge clk); #1;

        // reset state
        cycle();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b0;

        // independent addi x1..x4
        do_reset();
        t0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            set_op(1'b0, 1'b1, 4'd0, 5'd0, 5'd0, 5'(i), 12'(i));
            cycle();
        end
        idle(8);
        chk("ind_n_iss", obs_iss_cyc.size(), 32'd4);
        chk("ind_first_iss", iss_at(5'd1) - t0, 32'd2);
        chk("ind_last_iss", iss_at(5'd4) - t0, 32'd5);
        chk("ind_first_wb", wb_at(5'd1) - t0, 32'd4);
        chk("ind_last_wb", wb_at(5'd4) - t0, 32'd7);
        chk("ind_stall", 32'(stall_cnt), 32'd0);

        // RAW: add x5,x1,x2 ; sub x6,x5,x3
        do_reset();
        t0 = cyc;
        set_op(1'b0, 1'b0, 4'd0, 5'd1, 5'd2, 5'd5, 12'd0); cycle();
        set_op(1'b0, 1'b0, 4'd1, 5'd5, 5'd3, 5'd6, 12'd0); cycle();
        idle(8);
        chk("raw_prod_iss", iss_at(5'd5) - t0, 32'd2);
        chk("raw_prod_wb", wb_at(5'd5) - t0, 32'd4);
        chk("raw_cons_iss", iss_at(5'd6) - t0, 32'd5);
        chk("raw_stall", 32'(stall_cnt), 32'd2);

        // x0 and I-type rs2 never stall
        do_reset();
        t0 = cyc;
        set_op(1'b0, 1'b1, 4'd0, 5'd0, 5'd0, 5'd0, 12'd7); cycle();
        set_op(1'b0, 1'b1, 4'd0, 5'd0, 5'd0, 5'd3, 12'd1); cycle();
        set_op(1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd7, 12'd0); cycle();
        set_op(1'b0, 1'b1, 4'd5, 5'd9, 5'd3, 5'd8, 12'd2); cycle();
        idle(8);
        chk("x0_wb_rd0", wb_at(5'd0) - t0, 32'd4);
        chk("x0_add_iss", iss_at(5'd7) - t0, 32'd4);
        chk("imm_slli_iss", iss_at(5'd8) - t0, 32'd5);
        chk("x0_stall", 32'(stall_cnt), 32'd0);

        // full FIFO, illegal op, NOP
        do_reset();
        stall_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(1'b0, 1'b1, 4'd2, 5'd0, 5'd0, 5'(11 + i), 12'd0);
            cycle();
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle();
        in_valid = 1'b0; stall_in = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle(4);
        chk("full_flush_no_iss", obs_iss_cyc.size(), 32'd0);
        set_op(1'b0, 1'b0, 4'hC, 5'd0, 5'd0, 5'd9, 12'd0); cycle();
        chk("illegal_pulse", 32'(err_illegal), 32'd1);
        idle(1);
        chk("illegal_pulse_end", 32'(err_illegal), 32'd0);
        set_op(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd9, 12'd0); cycle();
        idle(5);
        chk("illegal_nop_no_iss", obs_iss_cyc.size(), 32'd0);
        chk("illegal_in_ready", 32'(in_ready), 32'd1);

        // flush with one op in flight
        do_reset();
        t0 = cyc;
        set_op(1'b0, 1'b1, 4'd0, 5'd0, 5'd0, 5'd10, 12'd0); cycle();
        set_op(1'b0, 1'b1, 4'd0, 5'd0, 5'd0, 5'd20, 12'd0); cycle();
        stall_in = 1'b1;
        set_op(1'b0, 1'b1, 4'd0, 5'd0, 5'd0, 5'd21, 12'd0); cycle();
        set_op(1'b0, 1'b1, 4'd0, 5'd0, 5'd0, 5'd22, 12'd0); cycle();
        in_valid = 1'b0; stall_in = 1'b0; flush = 1'b1; cycle();
        flush = 1'b0;
        idle(5);
        chk("flush_n_iss", obs_iss_cyc.size(), 32'd1);
        chk("flush_inflight_wb", wb_at(5'd10) - t0, 32'd4);
        t0 = cyc;
        set_op(1'b0, 1'b0, 4'd0, 5'd10, 5'd10, 5'd11, 12'd0); cycle();
        idle(4);
        chk("flush_dep_iss", iss_at(5'd11) - t0, 32'd2);
        chk("flush_stall", 32'(stall_cnt), 32'd0);

        // reset mid-run with busy bits set
        do_reset();
        set_op(1'b0, 1'b1, 4'd0, 5'd0, 5'd0, 5'd1, 12'd0); cycle();
        set_op(1'b0, 1'b1, 4'd0, 5'd0, 5'd0, 5'd2, 12'd0); cycle();
        idle(1);
        rst = 1'b1; cycle();
        chk("mid_rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("mid_rst_iss_rd", 32'(iss_rd), 32'd0);
        chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        rst = 1'b0;
        obs_iss_cyc.delete(); obs_iss_rd.delete(); obs_wb_cyc.delete(); obs_wb_rd.delete();
        t0 = cyc;
        set_op(1'b0, 1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 12'd0); cycle();
        idle(6);
        chk("post_rst_dep_iss", iss_at(5'd3) - t0, 32'd2);
        chk("post_rst_n_wb", obs_wb_cyc.size(), 32'd1);
        chk("post_rst_stall", 32'(stall_cnt), 32'd0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_is_nop = ($urandom_range(0, 9) == 0);
            in_is_imm = $urandom_range(0, 1);
            in_op     = 4'($urandom_range(0, 11));
            in_rs1    = 5'($urandom_range(0, 7));
            in_rs2    = 5'($urandom_range(0, 7));
            in_rd     = 5'($urandom_range(0, 7));
            in_imm    = 12'($urandom);
            stall_in  = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0; flush = 1'b0; stall_in = 1'b0;
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
